// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
interface data_memory_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    writeData;
    logic [1:0]               size;
    logic                     signedLoad;
    logic                     memoryRead;
    logic                     memoryWrite;
    logic [DATA_WIDTH-1:0]    readData;
    logic                     readValid;
    logic                     ready;
    logic                     fault;

    modport master (
        output address, writeData, size, signedLoad, memoryRead, memoryWrite,
        input  readData, readValid, ready, fault
    );

    modport slave (
        input  address, writeData, size, signedLoad, memoryRead, memoryWrite,
        output readData, readValid, ready, fault
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with sub-word loads/stores, wait states
// and fault reporting for misaligned or illegal requests.
module data_memory_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = 10,
    parameter int WAIT_STATES   = 1
) (
    input logic                clk_i,
    input logic                rst_n_i,
    data_memory_ctrl_if.slave  bus_io
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(NUM_BYTES);
    localparam int IDX_W     = ADDRESS_WIDTH - OFF_W;
    localparam logic [3:0] NUM_BYTES_L = 4'(NUM_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [1:0]               size_q;
    logic                     signed_q;
    logic                     isWrite_q;
    logic [DATA_WIDTH-1:0]    readData_q;
    logic                     readValid_q;
    logic                     fault_q;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                     ready;
    logic                     accept;
    logic                     reject;
    logic [3:0]               sizeBytes;
    logic                     misaligned;
    logic                     completing;
    logic                     memWe;
    logic [IDX_W-1:0]         wordIdx;
    logic [OFF_W-1:0]         offset;
    logic [DATA_WIDTH-1:0]    readWord;
    logic [DATA_WIDTH-1:0]    extracted;
    logic [DATA_WIDTH-1:0]    loadValue;
    logic [DATA_WIDTH-1:0]    storeData;
    logic [NUM_BYTES-1:0]     laneMask;
    logic [NUM_BYTES-1:0]     byteMask;
    logic                     signBit;
    int                       accessBits;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Fault checks look only at the live bus; a rejected request never leaves IDLE.
    always_comb begin
        sizeBytes  = 4'd1 << bus_io.size;
        misaligned = (bus_io.address[2:0] & 3'(sizeBytes - 4'd1)) != 3'd0;
        reject     = (bus_io.memoryRead & bus_io.memoryWrite) |
                     (sizeBytes > NUM_BYTES_L) | misaligned;
        accept     = (state_q == IDLE) & (bus_io.memoryRead | bus_io.memoryWrite);
        state_d    = state_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (accept && !reject) begin
                    if (WAIT_STATES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        count_d = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready      = (state_q == IDLE);
        completing = (state_q == DONE);
        memWe      = completing & isWrite_q;
        wordIdx    = addr_q[ADDRESS_WIDTH-1:OFF_W];
        offset     = addr_q[OFF_W-1:0];
        readWord   = mem[wordIdx];
        extracted  = readWord >> {offset, 3'b000};
        storeData  = wdata_q << {offset, 3'b000};

        case (size_q)
            2'd0: begin accessBits = 8;  signBit = extracted[7];  laneMask = NUM_BYTES'(8'h01); end
            2'd1: begin accessBits = 16; signBit = extracted[15]; laneMask = NUM_BYTES'(8'h03); end
            2'd2: begin accessBits = 32; signBit = extracted[31]; laneMask = NUM_BYTES'(8'h0F); end
            default: begin
                accessBits = DATA_WIDTH;
                signBit    = extracted[DATA_WIDTH-1];
                laneMask   = '1;
            end
        endcase
        byteMask = laneMask << offset;

        loadValue = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            loadValue[i] = (i < accessBits) ? extracted[i] : (signed_q & signBit);
        end

        bus_io.ready     = ready;
        bus_io.readData  = readData_q;
        bus_io.readValid = readValid_q;
        bus_io.fault     = fault_q;
    end

    // Request fields are captured once at acceptance so the master may change the bus while we stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            isWrite_q   <= 1'b0;
            readData_q  <= '0;
            readValid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            fault_q     <= accept & reject;
            readValid_q <= completing & ~isWrite_q;
            if (accept && !reject) begin
                addr_q    <= bus_io.address;
                wdata_q   <= bus_io.writeData;
                size_q    <= bus_io.size;
                signed_q  <= bus_io.signedLoad;
                isWrite_q <= bus_io.memoryWrite;
            end
            if (completing && !isWrite_q) begin
                readData_q <= loadValue;
            end
        end
    end

    // The array is not reset; a reset aborts the access because state_q drops out of DONE.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (byteMask[b]) begin
                    mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: one controller with one wait state, one with none, sharing a clock.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rstN1;
    logic rstN0;

    always #5 clk = ~clk;

    data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10)) b1 ();
    data_memory_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10)) b0 ();

    data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(256), .ADDRESS_WIDTH(10), .WAIT_STATES(1)) dut1 (
        .clk_i   (clk),
        .rst_n_i (rstN1),
        .bus_io  (b1.slave)
    );

    data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(256), .ADDRESS_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk_i   (clk),
        .rst_n_i (rstN0),
        .bus_io  (b0.slave)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastRead1 = 32'h0;

    task automatic fail(input string name, input logic [31:0] got, input logic [31:0] want);
        errors++;
        $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Full transaction on the one-wait-state controller with cycle-exact handshake checks.
    task automatic access1(input string name, input logic [9:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sgn, input logic rd, input logic wr,
                           input logic expFault, input logic [31:0] expData);
        logic [31:0] want;
        @(negedge clk);
        b1.address     = addr;
        b1.writeData   = wd;
        b1.size        = sz;
        b1.signedLoad  = sgn;
        b1.memoryRead  = rd;
        b1.memoryWrite = wr;
        if (rd && !wr && !expFault) expQ.push_back(expData);
        @(negedge clk);
        b1.memoryRead  = 1'b0;
        b1.memoryWrite = 1'b0;
        if (expFault) begin
            checks++; if (b1.fault !== 1'b1) fail({name, " fault"}, 32'(b1.fault), 32'h1);
            checks++; if (b1.ready !== 1'b1) fail({name, " ready"}, 32'(b1.ready), 32'h1);
            checks++; if (b1.readValid !== 1'b0) fail({name, " readValid"}, 32'(b1.readValid), 32'h0);
            @(negedge clk);
            checks++; if (b1.fault !== 1'b0) fail({name, " fault clear"}, 32'(b1.fault), 32'h0);
        end else begin
            checks++; if (b1.ready !== 1'b0) fail({name, " busy1"}, 32'(b1.ready), 32'h0);
            @(negedge clk);
            checks++; if (b1.ready !== 1'b0) fail({name, " busy2"}, 32'(b1.ready), 32'h0);
            @(negedge clk);
            checks++; if (b1.ready !== 1'b1) fail({name, " ready"}, 32'(b1.ready), 32'h1);
            checks++; if (b1.readValid !== rd) fail({name, " readValid"}, 32'(b1.readValid), 32'(rd));
            if (b1.readValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    fail({name, " unexpected read"}, b1.readData, 32'h0);
                end else begin
                    want = expQ.pop_front();
                    checks++; if (b1.readData !== want) fail({name, " data"}, b1.readData, want);
                    lastRead1 = want;
                end
            end else begin
                checks++; if (b1.readData !== lastRead1) fail({name, " hold"}, b1.readData, lastRead1);
            end
            @(negedge clk);
            checks++; if (b1.readValid !== 1'b0) fail({name, " pulse"}, 32'(b1.readValid), 32'h0);
        end
    endtask

    task automatic write0(input logic [9:0] addr, input logic [31:0] wd);
        @(negedge clk);
        b0.address     = addr;
        b0.writeData   = wd;
        b0.size        = 2'd2;
        b0.memoryWrite = 1'b1;
        @(negedge clk);
        b0.memoryWrite = 1'b0;
        checks++; if (b0.ready !== 1'b0) fail("ws0 write busy", 32'(b0.ready), 32'h0);
        @(negedge clk);
        checks++; if (b0.ready !== 1'b1) fail("ws0 write ready", 32'(b0.ready), 32'h1);
    endtask

    task automatic test_reset();
        rstN1 = 1'b0;
        rstN0 = 1'b0;
        b1.address = '0; b1.writeData = '0; b1.size = 2'd0; b1.signedLoad = 1'b0;
        b1.memoryRead = 1'b0; b1.memoryWrite = 1'b0;
        b0.address = '0; b0.writeData = '0; b0.size = 2'd0; b0.signedLoad = 1'b0;
        b0.memoryRead = 1'b0; b0.memoryWrite = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (b1.ready !== 1'b1) fail("reset ready", 32'(b1.ready), 32'h1);
        checks++; if (b1.readValid !== 1'b0) fail("reset readValid", 32'(b1.readValid), 32'h0);
        checks++; if (b1.fault !== 1'b0) fail("reset fault", 32'(b1.fault), 32'h0);
        checks++; if (b1.readData !== 32'h0) fail("reset readData", b1.readData, 32'h0);
        checks++; if (b0.ready !== 1'b1) fail("reset ready ws0", 32'(b0.ready), 32'h1);
        rstN1 = 1'b1;
        rstN0 = 1'b1;
    endtask

    task automatic test_word();
        access1("word write", 10'h010, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        access1("word read", 10'h010, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_byte_store();
        access1("byte store", 10'h011, 32'hFFFFFF7F, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        access1("merged read", 10'h010, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD7FEF);
    endtask

    task automatic test_loads();
        access1("sbyte 13", 10'h013, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFDE);
        access1("ubyte 13", 10'h013, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h000000DE);
        access1("uhalf 12", 10'h012, 32'h0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000DEAD);
        access1("shalf 10", 10'h010, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00007FEF);
    endtask

    task automatic test_faults();
        access1("misaligned half write", 10'h011, 32'h0000AAAA, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        access1("read and write", 10'h010, 32'h11111111, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        access1("size 64", 10'h010, 32'h0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        access1("misaligned word read", 10'h012, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        access1("after faults", 10'h010, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD7FEF);
    endtask

    task automatic test_reset_mid();
        access1("pre write 20", 10'h020, 32'h0BADF00D, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        b1.address     = 10'h020;
        b1.writeData   = 32'h12345678;
        b1.size        = 2'd2;
        b1.memoryWrite = 1'b1;
        @(negedge clk);
        b1.memoryWrite = 1'b0;
        checks++; if (b1.ready !== 1'b0) fail("mid busy", 32'(b1.ready), 32'h0);
        rstN1 = 1'b0;
        #1;
        checks++; if (b1.ready !== 1'b1) fail("mid async ready", 32'(b1.ready), 32'h1);
        checks++; if (b1.readData !== 32'h0) fail("mid readData", b1.readData, 32'h0);
        @(negedge clk);
        rstN1 = 1'b1;
        lastRead1 = 32'h0;
        @(negedge clk);
        checks++; if (b1.readValid !== 1'b0) fail("mid readValid", 32'(b1.readValid), 32'h0);
        access1("read 20 after abort", 10'h020, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BADF00D);
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        logic        expOdd;
        int          pulses = 0;
        write0(10'h004, 32'hCAFE0004);
        @(negedge clk);
        b0.address    = 10'h004;
        b0.size       = 2'd2;
        b0.signedLoad = 1'b0;
        b0.memoryRead = 1'b1;
        expQ.push_back(32'hCAFE0004);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expOdd = (k % 2) == 1;
            checks++; if (b0.ready !== expOdd) fail("b2b ready", 32'(b0.ready), 32'(expOdd));
            checks++; if (b0.readValid !== expOdd) fail("b2b readValid", 32'(b0.readValid), 32'(expOdd));
            if (b0.readValid === 1'b1) begin
                pulses++;
                if (expQ.size() == 0) begin
                    fail("b2b unexpected read", b0.readData, 32'h0);
                end else begin
                    want = expQ.pop_front();
                    checks++; if (b0.readData !== want) fail("b2b data", b0.readData, want);
                end
            end
            if (expOdd && k < 7) expQ.push_back(32'hCAFE0004);
        end
        b0.memoryRead = 1'b0;
        @(negedge clk);
        checks++; if (b0.readValid !== 1'b0) fail("b2b tail", 32'(b0.readValid), 32'h0);
        checks++; if (pulses !== 4) fail("b2b pulses", 32'(pulses), 32'd4);
        checks++; if (expQ.size() !== 0) fail("b2b queue", 32'(expQ.size()), 32'h0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_store();
        test_loads();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressed data memory for the pipelined MIPS core; successor to the fixed 32-bit word-only data memory.
- Supports byte, half and word accesses with per-lane stores and sign/zero-extended loads.
- Adds a configurable wait-state counter with a Ready/ReadValid handshake so the MEM stage can stall on slow memory.
- Flags misaligned and illegal requests instead of corrupting memory.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be 32 or 64.
- DEPTH, 256: number of words.
- ADDRESS_WIDTH, 10: byte-address width. Equals log2(DEPTH) + log2(DATA_WIDTH/8).
- WAIT_STATES, 1: extra cycles inserted before an access completes. Range 0..15.

Ports:
- Clock, input, 1: single clock. All state updates on the rising edge.
- Reset_n, input, 1: reset, asynchronous assert, active-low.
- Address, input, ADDRESS_WIDTH: byte address. Little-endian.
- WriteData, input, DATA_WIDTH: store data. The low 2^Size bytes are used.
- Size, input, 2: access size. 00 byte, 01 half, 10 word32, 11 word64 (legal only when DATA_WIDTH=64).
- SignedLoad, input, 1: 1 = sign-extend loaded value, 0 = zero-extend.
- MemoryRead, input, 1: read request, sampled only while Ready=1.
- MemoryWrite, input, 1: write request, sampled only while Ready=1.
- ReadData, output, DATA_WIDTH: registered, extended load result.
- ReadValid, output, 1: one-cycle pulse when ReadData is updated.
- Ready, output, 1: block can accept a request this cycle.
- Fault, output, 1: one-cycle pulse for a rejected request.

Behaviour:
- Reset (Reset_n=0, async): ReadData=0, ReadValid=0, Ready=1, Fault=0, state=IDLE, wait counter=0. Memory array is not cleared.
- Reset mid-access aborts the access. A pending write is never committed. After release the block is in IDLE with Ready=1.
- States: IDLE, WAIT, DONE.
- Acceptance:
  - A request is accepted on a rising edge where Ready=1 and (MemoryRead or MemoryWrite)=1.
  - On acceptance, Address, WriteData, Size, SignedLoad and the direction are latched.
  - Requests while Ready=0 are ignored. There is no queuing.
- Fault check at acceptance. A request is rejected if any of these holds:
  - MemoryRead and MemoryWrite are both 1;
  - 2^Size > DATA_WIDTH/8;
  - Address is not aligned to 2^Size bytes.
- On a rejected request:
  - Fault=1 for the following cycle.
  - No memory change, ReadValid stays 0, Ready stays 1, state stays IDLE.
- Valid request (accepted at edge E0):
  - State goes to WAIT with counter=WAIT_STATES, and Ready=0.
  - The counter decrements each cycle in WAIT. At 0 the state moves to DONE; with WAIT_STATES=0, DONE is entered directly.
  - Completion happens on the edge that leaves DONE, at E0+WAIT_STATES+1.
  - Ready returns to 1 after the completion edge. The next acceptance is possible at E0+WAIT_STATES+2.
- Write completion:
  - Only the 2^Size byte lanes starting at offset Address[log2(DATA_WIDTH/8)-1:0] are written, using WriteData's low bytes.
  - All other lanes of the word are unchanged.
- Read completion:
  - The addressed lanes are extracted, shifted to bit 0, then sign- or zero-extended to DATA_WIDTH per SignedLoad.
  - The result is registered into ReadData. ReadValid=1 for exactly the cycle after the completion edge.
  - ReadData holds its value until the next read completion. Writes do not alter ReadData.
- A read of a location after a completed write to it returns the new data, since the write commits before Ready reasserts.
- Word index = Address[ADDRESS_WIDTH-1:log2(DATA_WIDTH/8)]. It always lies in range, so no wrap handling is needed.

Test Plan:
- Reset, WAIT_STATES=1:
  - Stimulus: word write 0xDEADBEEF @0x10, then word read @0x10.
  - Required: Ready low for 2 cycles per access. ReadValid pulses 2 cycles after read acceptance with ReadData=0xDEADBEEF.
- Byte store 0x7F @0x11 over 0xDEADBEEF, then word read @0x10:
  - Required: ReadData=0xDEAD7FEF.
- Loads from word 0xDEAD7FEF:
  - Signed byte @0x13 → 0xFFFFFFDE.
  - Unsigned half @0x12 → 0x0000DEAD.
  - Signed half @0x10 → 0x00007FEF.
- Faulted requests:
  - Half write @0x11 → Fault pulse, memory unchanged, Ready stays 1.
  - Both MemoryRead and MemoryWrite high → Fault pulse.
  - Size=11 with DATA_WIDTH=32 → Fault pulse.
- Reset mid-access: pull Reset_n low during WAIT of a word write 0x12345678 @0x20.
  - Required: Ready=1 immediately. A later read @0x20 returns the prior contents.
- WAIT_STATES=0 back-to-back reads: hold MemoryRead high.
  - Required: accepts every 2nd cycle. ReadValid pulses 1 cycle after each acceptance. Requests issued while Ready=0 produce no extra ReadValid.
